// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared state encoding, alignment mask and width defaults
package mem_stage_ctrl_pkg;
   localparam int DBITS_DEF = 32;
   localparam int REG_INDEX_BIT_WIDTH_DEF = 4;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: req/ack data-memory port between the memory stage and memory
interface mem_stage_ctrl_if import mem_stage_ctrl_pkg::*; #(parameter int DBITS = DBITS_DEF) ();
   logic             mem_req;
   logic             mem_we;
   logic [DBITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_wdata;
   logic [DBITS-1:0] mem_rdata;
   logic             mem_ack;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/Register.sv
// Register: enabled register with synchronous active-low reset
module Register #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wrt_en,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out
);
   logic [WIDTH-1:0] data_q, data_d;
   always_comb data_d = wrt_en ? data_in : data_q;
   always_ff @(posedge clk) data_q <= !reset ? RESET_VALUE : data_d;
   assign data_out = data_q;
endmodule

// File: rtl/mem_stage_ctrl_timeout.sv
// mem_timeout_counter: counts ack-wait cycles and flags the last allowed one
module mem_timeout_counter #(
   parameter int TIMEOUT = 16,
   parameter int TO_BITS = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [TO_BITS-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : en ? cnt_q + TO_BITS'(1) : cnt_q;
   always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
   assign expired = cnt_q == TO_BITS'(TIMEOUT - 1);
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: EX/MEM consumer that performs load/store and produces the MEM/WB payload
module mem_stage_ctrl import mem_stage_ctrl_pkg::*; #(
   parameter int DBITS = DBITS_DEF,
   parameter int REG_INDEX_BIT_WIDTH = REG_INDEX_BIT_WIDTH_DEF,
   parameter int TIMEOUT = 16,
   parameter int TO_BITS = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DBITS-1:0]               EX_intermediateResult,
   input  logic [DBITS-1:0]               EX_regData2,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] EX_rd,
   input  logic                           EX_ME_mux_sel,
   input  logic                           EX_wrReg,
   input  logic                           EX_wrMem,
   output logic                           ex_wrt_en,
   mem_stage_ctrl_if.master               mem,
   output logic [DBITS-1:0]               WB_data,
   output logic [REG_INDEX_BIT_WIDTH-1:0] WB_rd,
   output logic                           WB_wrReg,
   output logic                           mem_err
);
   state_t state_q, state_d;
   logic req_q, req_d, we_q, we_d, err_q, err_d, abort_q, abort_d;
   logic [DBITS-1:0] addr_q, addr_d, wdata_q, wdata_d, ld_buf_q, ld_buf_d, wb_data_d;
   logic wb_wrreg_d, mem_op, misaligned, go, expired, cnt_en;
   assign mem_op = EX_wrMem | (EX_ME_mux_sel & EX_wrReg);
   assign misaligned = |(EX_intermediateResult[1:0] & ALIGN_MASK);
   assign go = (state_q == IDLE) & mem_op & ~misaligned;
   always_comb begin
      state_d = state_q;
      req_d = req_q;
      we_d = we_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      ld_buf_d = ld_buf_q;
      err_d = err_q;
      abort_d = abort_q;
      cnt_en = 1'b0;
      ex_wrt_en = 1'b1;
      wb_data_d = EX_intermediateResult;
      wb_wrreg_d = 1'b0;
      case (state_q)
         IDLE: begin
            ex_wrt_en = ~go;
            wb_wrreg_d = EX_wrReg & ~mem_op;
            err_d = err_q | (mem_op & misaligned);
            if (go) begin
               state_d = WAIT;
               req_d = 1'b1;
               we_d = EX_wrMem;
               addr_d = EX_intermediateResult;
               wdata_d = EX_regData2;
               abort_d = 1'b0;
            end
         end
         WAIT: begin
            ex_wrt_en = 1'b0;
            if (mem.mem_ack) begin
               req_d = 1'b0;
               ld_buf_d = mem.mem_rdata;
               state_d = DONE;
            end else if (expired) begin
               req_d = 1'b0;
               err_d = 1'b1;
               abort_d = 1'b1;
               state_d = DONE;
            end else cnt_en = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            wb_data_d = (EX_ME_mux_sel & ~EX_wrMem) ? ld_buf_q : EX_intermediateResult;
            wb_wrreg_d = EX_wrReg & ~EX_wrMem & ~abort_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q <= 1'b0;
         we_q <= 1'b0;
         addr_q <= '0;
         wdata_q <= '0;
         ld_buf_q <= '0;
         err_q <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q <= req_d;
         we_q <= we_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         ld_buf_q <= ld_buf_d;
         err_q <= err_d;
         abort_q <= abort_d;
      end
   end
   mem_timeout_counter #(.TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) u_to (
      .clk(clk), .reset(reset), .clr(go), .en(cnt_en), .expired(expired)
   );
   Register #(.WIDTH(DBITS)) u_wb_data (
      .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(wb_data_d), .data_out(WB_data)
   );
   Register #(.WIDTH(REG_INDEX_BIT_WIDTH)) u_wb_rd (
      .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(EX_rd), .data_out(WB_rd)
   );
   Register #(.WIDTH(1)) u_wb_wr (
      .clk(clk), .reset(reset), .wrt_en(1'b1), .data_in(wb_wrreg_d), .data_out(WB_wrReg)
   );
   assign mem.mem_req = req_q;
   assign mem.mem_we = we_q;
   assign mem.mem_addr = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem_err = err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized instruction stream checked against a transaction-level model
module tb_mem_stage_ctrl;
   localparam int TIMEOUT = 16;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [31:0] EX_intermediateResult = '0, EX_regData2 = '0, WB_data;
   logic [3:0] EX_rd = '0, WB_rd;
   logic EX_ME_mux_sel = 1'b0, EX_wrReg = 1'b0, EX_wrMem = 1'b0;
   logic ex_wrt_en, WB_wrReg, mem_err;
   int checks = 0, failures = 0;
   bit model_err = 1'b0;
   mem_stage_ctrl_if #(.DBITS(32)) mif ();
   mem_stage_ctrl #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .TIMEOUT(TIMEOUT), .TO_BITS(5)) dut (
      .clk(clk), .reset(reset),
      .EX_intermediateResult(EX_intermediateResult), .EX_regData2(EX_regData2), .EX_rd(EX_rd),
      .EX_ME_mux_sel(EX_ME_mux_sel), .EX_wrReg(EX_wrReg), .EX_wrMem(EX_wrMem),
      .ex_wrt_en(ex_wrt_en), .mem(mif),
      .WB_data(WB_data), .WB_rd(WB_rd), .WB_wrReg(WB_wrReg), .mem_err(mem_err)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // delay = cycles mem_req is high before the bench acks; 0 = never ack
   task automatic run_instr(input logic [31:0] addr, input logic [31:0] d2, input logic [3:0] rd,
                            input bit mux, input bit wr, input bit wm, input int delay,
                            input logic [31:0] rv);
      bit op, mis, acc, to, done, prev_low, leak, bad_attr;
      int low, reqc, waited, exp_req;
      bit exp_wr;
      op = wm | (mux & wr);
      mis = addr[1:0] != 2'b00;
      acc = op & ~mis;
      to = acc & (delay == 0 || delay > TIMEOUT);
      exp_req = !acc ? 0 : to ? TIMEOUT : delay;
      exp_wr = !op ? wr : (acc & ~wm & ~to & wr);
      model_err = model_err | (op & mis) | to;
      EX_intermediateResult = addr;
      EX_regData2 = d2;
      EX_rd = rd;
      EX_ME_mux_sel = mux;
      EX_wrReg = wr;
      EX_wrMem = wm;
      mif.mem_ack = 1'b0;
      done = 1'b0;
      prev_low = 1'b0;
      leak = 1'b0;
      bad_attr = 1'b0;
      low = 0;
      reqc = 0;
      waited = 0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         if (mif.mem_req) begin
            reqc++;
            if (mif.mem_addr !== addr || mif.mem_we !== wm || mif.mem_wdata !== d2) bad_attr = 1'b1;
         end
         if (prev_low && WB_wrReg !== 1'b0) leak = 1'b1;
         done = ex_wrt_en;
         prev_low = !ex_wrt_en;
         if (!ex_wrt_en) low++;
         @(posedge clk);
         #1;
         mif.mem_ack = 1'b0;
         if (mif.mem_req) begin
            waited++;
            if (waited == delay) begin
               mif.mem_ack = 1'b1;
               mif.mem_rdata = rv;
            end
         end
      end
      mif.mem_ack = 1'b0;
      chk("completes", done, 1'b1);
      chk("stall_cycles", low, acc ? 1 + exp_req : 0);
      chk("req_cycles", reqc, exp_req);
      chk("req_attrs_stable", bad_attr, 1'b0);
      chk("wb_wr_during_stall", leak, 1'b0);
      chk("wb_wrreg", WB_wrReg, exp_wr);
      if (!mis) chk("wb_rd", WB_rd, rd);
      if (!op || (acc && wm)) chk("wb_data_alu", WB_data, addr);
      if (acc && !wm && !to) chk("wb_data_load", WB_data, rv);
      chk("mem_err", mem_err, model_err);
   endtask
   initial begin
      mif.mem_ack = 1'b0;
      mif.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", mif.mem_req, 1'b0);
      chk("rst_we", mif.mem_we, 1'b0);
      chk("rst_addr", mif.mem_addr, 32'h0);
      chk("rst_wdata", mif.mem_wdata, 32'h0);
      chk("rst_wb", {WB_data, WB_rd, WB_wrReg}, 37'h0);
      chk("rst_err", mem_err, 1'b0);
      reset = 1'b1;
      run_instr(32'h1234, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0, 1, 32'h0);
      run_instr(32'h40, 32'h0, 4'd3, 1'b1, 1'b1, 1'b0, 3, 32'hDEADBEEF);
      run_instr(32'h80, 32'hA5A5A5A5, 4'd7, 1'b0, 1'b0, 1'b1, 1, 32'h0);
      run_instr(32'h42, 32'h0, 4'd3, 1'b1, 1'b1, 1'b0, 1, 32'h0);
      run_instr(32'h44, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, 0, 32'h0);
      run_instr(32'h55, 32'h0, 4'd9, 1'b0, 1'b1, 1'b0, 1, 32'h0);
      run_instr(32'h48, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, TIMEOUT, 32'h13579BDF);
      run_instr(32'h4C, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, TIMEOUT + 1, 32'h0);
      run_instr(32'h50, 32'h11, 4'd6, 1'b1, 1'b1, 1'b1, 2, 32'h0);
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         int dly;
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         dly = $urandom_range(0, 7) == 0 ? $urandom_range(0, TIMEOUT + 2) : $urandom_range(1, 4);
         run_instr(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                   dly, $urandom);
      end
      EX_intermediateResult = 32'h100;
      EX_rd = 4'd4;
      EX_ME_mux_sel = 1'b1;
      EX_wrReg = 1'b1;
      EX_wrMem = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_req", mif.mem_req, 1'b1);
      reset = 1'b0;
      EX_ME_mux_sel = 1'b0;
      EX_wrReg = 1'b0;
      model_err = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk("midrst_req", mif.mem_req, 1'b0);
      chk("midrst_wb", {WB_data, WB_rd, WB_wrReg}, 37'h0);
      chk("midrst_err", mem_err, 1'b0);
      mif.mem_ack = 1'b1;
      mif.mem_rdata = 32'hBAD0BAD0;
      @(posedge clk);
      #1;
      mif.mem_ack = 1'b0;
      chk("late_ack_req", mif.mem_req, 1'b0);
      chk("late_ack_err", mem_err, 1'b0);
      run_instr(32'h2468, 32'h0, 4'd8, 1'b0, 1'b1, 1'b0, 1, 32'h0);
      run_instr(32'h200, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, 2, 32'hCAFEF00D);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage controller on the consumer side of the EX/MEM pipeline register.
- Consumes that register's outputs and performs load/store through a req/ack data-memory port.
- Drives the register's write enable low while an access is outstanding.
- Produces the registered MEM/WB payload (write-back data, destination, write enable) and a sticky memory-error flag.

Parameters:
DBITS, 32, datapath/address width
REG_INDEX_BIT_WIDTH, 4, register-index width
TIMEOUT, 16, max cycles waiting for mem_ack before abort (>=2)
TO_BITS, 5, timeout counter width (must hold TIMEOUT)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
EX_intermediateResult  input  DBITS  ALU result / byte address
EX_regData2  input  DBITS  store data
EX_rd  input  REG_INDEX_BIT_WIDTH  destination register
EX_ME_mux_sel  input  1  1 = load (write-back from memory), 0 = ALU result
EX_wrReg  input  1  instruction writes register file
EX_wrMem  input  1  store
ex_wrt_en  output  1  write enable back to the EX/MEM register (0 = hold)
mem_req  output  1  memory request, level, held until ack
mem_we  output  1  1 = store
mem_addr  output  DBITS  byte address, word aligned
mem_wdata  output  DBITS  store data
mem_rdata  input  DBITS  load data, valid in mem_ack cycle
mem_ack  input  1  one-cycle completion pulse
WB_data  output  DBITS  write-back data
WB_rd  output  REG_INDEX_BIT_WIDTH  write-back destination
WB_wrReg  output  1  write-back enable
mem_err  output  1  sticky: misaligned access or timeout

Behaviour:
- mem op = EX_wrMem | (EX_ME_mux_sel & EX_wrReg). EX_wrMem has priority if both are set (treated as a store; no write-back).
- Reset (reset==0 at edge): state IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, WB_data=0, WB_rd=0, WB_wrReg=0, mem_err=0, counter=0. Reset mid-access drops mem_req the next cycle; a late ack is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no mem op:
  - ex_wrt_en=1.
  - Next edge: WB_data=EX_intermediateResult, WB_rd=EX_rd, WB_wrReg=EX_wrReg. Latency 1 cycle.
- IDLE, mem op, address[1:0]!=0:
  - No access is made. ex_wrt_en=1.
  - mem_err<=1. WB_wrReg<=0 (instruction is dropped).
- IDLE, mem op, aligned:
  - ex_wrt_en=0 (combinational).
  - WB_wrReg<=0 (bubble).
  - Latch mem_addr, mem_wdata, mem_we=EX_wrMem. mem_req<=1, counter<=0. Go to WAIT.
- WAIT:
  - ex_wrt_en=0, WB_wrReg<=0 each cycle.
  - mem_ack=1: mem_req<=0, capture mem_rdata into an internal load buffer, go to DONE.
  - No ack with counter==TIMEOUT-1: mem_req<=0, mem_err<=1, set the abort flag, go to DONE.
  - Otherwise counter++.
- DONE:
  - ex_wrt_en=1. Next edge goes to IDLE.
  - WB_rd=EX_rd.
  - WB_data = load buffer for a load, else EX_intermediateResult.
  - WB_wrReg = EX_wrReg & ~EX_wrMem & ~abort.
- Aligned-access latency: 2 + ack-wait cycles, e.g. ack in the first WAIT cycle gives 3 cycles with ex_wrt_en low for 2.
- mem_ack in IDLE or DONE is ignored.
- mem_req/addr/wdata/we are stable for the whole WAIT interval.
- mem_err clears only on reset.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), the alignment mask constant, and the DBITS/REG_INDEX_BIT_WIDTH defaults.
- One natural sub-module: mem_timeout_counter (clear, enable, TIMEOUT compare, expired flag).
- WB outputs use the existing Register module with reset value 0.

Test Plan:
- ALU op: EX_intermediateResult=0x1234, EX_rd=5, EX_wrReg=1, mux_sel=0 -> next cycle WB_data=0x1234, WB_rd=5, WB_wrReg=1, ex_wrt_en stays 1, mem_req never asserted.
- Load: addr=0x40, rd=3, mux_sel=1, wrReg=1, ack on 3rd WAIT cycle with rdata=0xDEADBEEF -> mem_req high 3 cycles with mem_addr=0x40, mem_we=0; ex_wrt_en low 4 cycles; then WB_data=0xDEADBEEF, WB_rd=3, WB_wrReg=1 for one cycle.
- Store: addr=0x80, regData2=0xA5A5A5A5, wrMem=1, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5; WB_wrReg stays 0 throughout.
- Misaligned load at addr 0x42 -> mem_req never asserted, mem_err=1 next cycle, WB_wrReg=0, ex_wrt_en never low.
- Timeout: load with mem_ack held 0, TIMEOUT=16 -> mem_req drops after 16 cycles, mem_err=1, WB_wrReg=0; a following ALU op completes normally.
- Reset pulse during WAIT -> next cycle mem_req=0, all WB outputs 0, mem_err=0; a late ack is ignored.
